// File: rtl/router_pkg.sv
// router_pkg: shared types and constants for the router packet transmitter.
package router_pkg;

    localparam int unsigned LEN_W        = 6;
    localparam int unsigned BUF_DEPTH    = 64;
    localparam int unsigned GAP_CYCLES   = 1;
    localparam logic [1:0]  ADDR_INVALID = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StHdr,
        StPayload,
        StParity,
        StGap
    } tx_state_t;

    // Router header byte: length in the upper six bits, destination in the lower two.
    function automatic logic [7:0] make_header(input logic [LEN_W-1:0] len,
                                               input logic [1:0]       addr);
        return {len, addr};
    endfunction

endpackage

// File: rtl/router_tx_buf.sv
// router_tx_buf: payload staging buffer, synchronous write, combinational read.
module router_tx_buf
    import router_pkg::*;
(
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [LEN_W-1:0] waddr_i,
    input  logic [7:0]       wdata_i,
    input  logic [LEN_W-1:0] raddr_i,
    output logic [7:0]       rdata_o
);

    // Data array is never reset; stale contents are unreachable once indices are cleared.
    logic [7:0] mem_q [BUF_DEPTH];

    // Write one payload byte per accepted beat.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/router_pkt_tx.sv
// router_pkt_tx: stages one request's payload, then sends header, payload and parity
// to the router ingress while honouring busy back-pressure.
// Build macro ROUTER_TX_PARITY_INJ_EN adds inj_err, which flips parity bit 0 for the
// packet whose request is accepted while it is high.
module router_pkt_tx
    import router_pkg::*;
#(
    parameter int unsigned MAX_LEN = 63
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_addr,
    input  logic [LEN_W-1:0] req_len,
    input  logic             pl_valid,
    output logic             pl_ready,
    input  logic [7:0]       pl_data,
    input  logic             busy,
`ifdef ROUTER_TX_PARITY_INJ_EN
    input  logic             inj_err,
`endif
    output logic             pkt_valid,
    output logic [7:0]       data_out,
    output logic             req_drop,
    output logic             tx_done
);

    localparam logic [LEN_W:0] MaxLenExt = MAX_LEN[LEN_W:0];

    tx_state_t        state_q, state_d;
    logic [1:0]       addr_q, addr_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] wr_idx_q, wr_idx_d;
    logic [LEN_W-1:0] rd_idx_q, rd_idx_d;
    logic [7:0]       parity_q, parity_d;
    logic [1:0]       gap_cnt_q, gap_cnt_d;
    logic             pkt_valid_q, pkt_valid_d;
    logic [7:0]       data_out_q, data_out_d;
    logic             req_drop_q, req_drop_d;
    logic             tx_done_q, tx_done_d;

    logic [7:0] header;
    logic [7:0] parity_tx;
    logic [7:0] buf_rdata;
    logic       req_bad, accept, wr_fire, last_wr, last_rd, gap_last;

    assign header   = make_header(len_q, addr_q);
    assign req_bad  = (req_addr == ADDR_INVALID) || (req_len == '0)
                   || ({1'b0, req_len} > MaxLenExt);
    assign accept   = (state_q == StIdle) && req_valid && !req_bad;
    assign wr_fire  = (state_q == StLoad) && pl_valid;
    assign last_wr  = (wr_idx_q == len_q - LEN_W'(1));
    assign last_rd  = (rd_idx_q == len_q - LEN_W'(1));
    assign gap_last = (gap_cnt_q == 2'(GAP_CYCLES - 1));

`ifdef ROUTER_TX_PARITY_INJ_EN
    logic inj_q;

    // Corruption flag belongs to the packet accepted with it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inj_q <= 1'b0;
        end else if (accept) begin
            inj_q <= inj_err;
        end
    end

    assign parity_tx = parity_q ^ {7'b0, inj_q};
`else
    assign parity_tx = parity_q;
`endif

    router_tx_buf u_buf (
        .clk_i   (clk),
        .we_i    (wr_fire),
        .waddr_i (wr_idx_q),
        .wdata_i (pl_data),
        .raddr_i (rd_idx_d),
        .rdata_o (buf_rdata)
    );

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; any busy-gated state simply holds while busy is high.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (accept)             state_d = StLoad;
            StLoad:    if (wr_fire && last_wr) state_d = StHdr;
            StHdr:     if (!busy)              state_d = StPayload;
            StPayload: if (!busy && last_rd)   state_d = StParity;
            StParity:  if (!busy)              state_d = StGap;
            StGap:     if (gap_last)           state_d = StIdle;
            default:                           state_d = StIdle;
        endcase
    end

    // Request latch, running parity and buffer indices.
    always_comb begin
        addr_d    = addr_q;
        len_d     = len_q;
        parity_d  = parity_q;
        wr_idx_d  = wr_idx_q;
        rd_idx_d  = rd_idx_q;
        gap_cnt_d = '0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    addr_d   = req_addr;
                    len_d    = req_len;
                    parity_d = make_header(req_len, req_addr);
                    wr_idx_d = '0;
                    rd_idx_d = '0;
                end
            end
            StLoad: begin
                if (wr_fire) begin
                    parity_d = parity_q ^ pl_data;
                    wr_idx_d = last_wr ? '0 : wr_idx_q + LEN_W'(1);
                end
            end
            StHdr: rd_idx_d = '0;
            StPayload: begin
                if (!busy) begin
                    rd_idx_d = last_rd ? '0 : rd_idx_q + LEN_W'(1);
                end
            end
            StGap: gap_cnt_d = gap_last ? 2'd0 : gap_cnt_q + 2'd1;
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_q    <= '0;
            len_q     <= '0;
            parity_q  <= '0;
            wr_idx_q  <= '0;
            rd_idx_q  <= '0;
            gap_cnt_q <= '0;
        end else begin
            addr_q    <= addr_d;
            len_q     <= len_d;
            parity_q  <= parity_d;
            wr_idx_q  <= wr_idx_d;
            rd_idx_q  <= rd_idx_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    // Output decode; the router-facing byte is chosen from the state being entered.
    always_comb begin
        req_ready   = (state_q == StIdle);
        pl_ready    = (state_q == StLoad);
        req_drop_d  = (state_q == StIdle) && req_valid && req_bad;
        tx_done_d   = (state_q == StParity) && !busy;
        pkt_valid_d = 1'b0;
        data_out_d  = '0;
        unique case (state_d)
            StHdr: begin
                pkt_valid_d = 1'b1;
                data_out_d  = header;
            end
            StPayload: begin
                pkt_valid_d = 1'b1;
                data_out_d  = buf_rdata;
            end
            StParity: data_out_d = parity_tx;
            default: ;
        endcase
    end

    // Registered router-side outputs and status pulses.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pkt_valid_q <= 1'b0;
            data_out_q  <= '0;
            req_drop_q  <= 1'b0;
            tx_done_q   <= 1'b0;
        end else begin
            pkt_valid_q <= pkt_valid_d;
            data_out_q  <= data_out_d;
            req_drop_q  <= req_drop_d;
            tx_done_q   <= tx_done_d;
        end
    end

    assign pkt_valid = pkt_valid_q;
    assign data_out  = data_out_q;
    assign req_drop  = req_drop_q;
    assign tx_done   = tx_done_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// tb_router_pkt_tx: table-driven directed packets, corner sequences and randomized
// packets checked against a byte-stream model of the router packet format.
module tb_router_pkt_tx;

    logic       clk = 1'b0;
    logic       resetn;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_addr;
    logic [5:0] req_len;
    logic       pl_valid;
    logic       pl_ready;
    logic [7:0] pl_data;
    logic       busy;
    logic       pkt_valid;
    logic [7:0] data_out;
    logic       req_drop;
    logic       tx_done;
`ifdef ROUTER_TX_PARITY_INJ_EN
    logic       inj_err;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] pl_q[$];
    logic [7:0] exp_d[$];
    logic       exp_v[$];

    typedef struct {
        logic [1:0] addr;
        logic [5:0] len;
        logic [7:0] p0;
        logic [7:0] p1;
        logic [7:0] p2;
        int         stall_pos;
        int         stall_cyc;
        logic       exp_drop;
        logic [7:0] exp_hdr;
        logic [7:0] exp_par;
    } vec_t;

    vec_t tbl[8];

    always #5 clk = ~clk;

    router_pkt_tx dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .pl_valid  (pl_valid),
        .pl_ready  (pl_ready),
        .pl_data   (pl_data),
        .busy      (busy),
`ifdef ROUTER_TX_PARITY_INJ_EN
        .inj_err   (inj_err),
`endif
        .pkt_valid (pkt_valid),
        .data_out  (data_out),
        .req_drop  (req_drop),
        .tx_done   (tx_done)
    );

    task automatic check1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h, expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: header {len,addr}, payload bytes, then XOR of all of them with valid low.
    task automatic build_expected(input logic [1:0] a, input logic [5:0] l, input logic ie);
        logic [7:0] par;
        exp_d.delete();
        exp_v.delete();
        par = {l, a};
        exp_d.push_back({l, a});
        exp_v.push_back(1'b1);
        foreach (pl_q[i]) begin
            par ^= pl_q[i];
            exp_d.push_back(pl_q[i]);
            exp_v.push_back(1'b1);
        end
        exp_d.push_back(par ^ {7'b0, ie});
        exp_v.push_back(1'b0);
    endtask

    // Called just after a falling edge; returns one falling edge after the request edge.
    task automatic send_req(input logic [1:0] a, input logic [5:0] l);
        req_valid = 1'b1;
        req_addr  = a;
        req_len   = l;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic load_payload(input bit gaps);
        foreach (pl_q[i]) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    pl_valid = 1'b0;
                    pl_data  = 8'($urandom);
                    busy     = 1'($urandom);
                    @(negedge clk);
                end
            end
            check1("pl_ready", pl_ready, 1'b1);
            pl_valid = 1'b1;
            pl_data  = pl_q[i];
            busy     = 1'($urandom);
            @(negedge clk);
        end
        pl_valid = 1'b0;
        busy     = 1'b0;
    endtask

    // Walks the expected stream; a position advances only on a cycle with busy low.
    task automatic capture(input int stall_pos, input int stall_cyc, input bit rnd,
                           input int abort_at);
        int   k    = 0;
        int   left = stall_cyc;
        logic b;
        while (k < exp_d.size()) begin
            check1($sformatf("byte%0d.valid", k), pkt_valid, exp_v[k]);
            check8($sformatf("byte%0d.data", k), data_out, exp_d[k]);
            check1("tx_done_early", tx_done, 1'b0);
            if (k == abort_at) begin
                #2 resetn = 1'b0;
                #1;
                check1("rst.pkt_valid", pkt_valid, 1'b0);
                check8("rst.data_out", data_out, 8'h00);
                check1("rst.req_ready", req_ready, 1'b1);
                check1("rst.pl_ready", pl_ready, 1'b0);
                check1("rst.tx_done", tx_done, 1'b0);
                busy      = 1'b0;
                req_valid = 1'b0;
                pl_valid  = 1'b0;
                @(negedge clk);
                resetn = 1'b1;
                return;
            end
            b = 1'b0;
            if (k == stall_pos && left > 0) begin
                b = 1'b1;
                left--;
            end else if (rnd) begin
                b = ($urandom_range(0, 3) == 0);
            end
            busy = b;
            if (rnd) begin
                req_valid = 1'($urandom);
                req_addr  = 2'($urandom_range(0, 2));
                req_len   = 6'($urandom_range(1, 63));
                pl_valid  = 1'($urandom);
                pl_data   = 8'($urandom);
            end
            @(negedge clk);
            if (!b) k++;
        end
        busy      = 1'b0;
        req_valid = 1'b0;
        pl_valid  = 1'b0;
        check1("gap.pkt_valid", pkt_valid, 1'b0);
        check8("gap.data_out", data_out, 8'h00);
        check1("gap.tx_done", tx_done, 1'b1);
        check1("gap.req_ready", req_ready, 1'b0);
        @(negedge clk);
        check1("idle.req_ready", req_ready, 1'b1);
        check1("idle.tx_done", tx_done, 1'b0);
        check1("idle.pkt_valid", pkt_valid, 1'b0);
    endtask

    task automatic check_drop();
        check1("drop.pulse", req_drop, 1'b1);
        check1("drop.pkt_valid", pkt_valid, 1'b0);
        check1("drop.req_ready", req_ready, 1'b1);
        @(negedge clk);
        check1("drop.end", req_drop, 1'b0);
        check1("drop.pkt_valid2", pkt_valid, 1'b0);
        check1("drop.req_ready2", req_ready, 1'b1);
    endtask

    initial begin
        tbl[0] = '{2'd1, 6'd3,  8'h11, 8'h22, 8'h33, -1, 0, 1'b0, 8'h0D, 8'h0D};
        tbl[1] = '{2'd1, 6'd3,  8'h11, 8'h22, 8'h33,  1, 2, 1'b0, 8'h0D, 8'h0D};
        tbl[2] = '{2'd3, 6'd5,  8'h00, 8'h00, 8'h00, -1, 0, 1'b1, 8'h00, 8'h00};
        tbl[3] = '{2'd0, 6'd0,  8'h00, 8'h00, 8'h00, -1, 0, 1'b1, 8'h00, 8'h00};
        tbl[4] = '{2'd2, 6'd1,  8'hA5, 8'h00, 8'h00, -1, 0, 1'b0, 8'h06, 8'hA3};
        tbl[5] = '{2'd0, 6'd2,  8'hFF, 8'h01, 8'h00,  0, 1, 1'b0, 8'h08, 8'hF6};
        tbl[6] = '{2'd1, 6'd3,  8'h00, 8'h00, 8'h00,  4, 3, 1'b0, 8'h0D, 8'h0D};
        tbl[7] = '{2'd3, 6'd0,  8'h00, 8'h00, 8'h00, -1, 0, 1'b1, 8'h00, 8'h00};

        resetn    = 1'b0;
        req_valid = 1'b0;
        req_addr  = 2'd0;
        req_len   = 6'd0;
        pl_valid  = 1'b0;
        pl_data   = 8'h00;
        busy      = 1'b0;
`ifdef ROUTER_TX_PARITY_INJ_EN
        inj_err   = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check1("reset.req_ready", req_ready, 1'b1);
        check1("reset.pl_ready", pl_ready, 1'b0);
        check1("reset.pkt_valid", pkt_valid, 1'b0);
        check8("reset.data_out", data_out, 8'h00);
        check1("reset.req_drop", req_drop, 1'b0);
        check1("reset.tx_done", tx_done, 1'b0);
        resetn = 1'b1;
        @(negedge clk);

        // Directed vectors.
        for (int i = 0; i < 8; i++) begin
            pl_q.delete();
            if (!tbl[i].exp_drop) begin
                pl_q.push_back(tbl[i].p0);
                if (tbl[i].len > 6'd1) pl_q.push_back(tbl[i].p1);
                if (tbl[i].len > 6'd2) pl_q.push_back(tbl[i].p2);
            end
            send_req(tbl[i].addr, tbl[i].len);
            if (tbl[i].exp_drop) begin
                check_drop();
            end else begin
                check1("accept.no_drop", req_drop, 1'b0);
                check1("accept.req_ready", req_ready, 1'b0);
                exp_d.delete();
                exp_v.delete();
                exp_d.push_back(tbl[i].exp_hdr);
                exp_v.push_back(1'b1);
                foreach (pl_q[j]) begin
                    exp_d.push_back(pl_q[j]);
                    exp_v.push_back(1'b1);
                end
                exp_d.push_back(tbl[i].exp_par);
                exp_v.push_back(1'b0);
                load_payload(1'b0);
                capture(tbl[i].stall_pos, tbl[i].stall_cyc, 1'b0, -1);
            end
        end

        // Maximum-length packet followed at once by a one-byte packet.
        pl_q.delete();
        for (int i = 0; i < 63; i++) pl_q.push_back(8'($urandom));
        build_expected(2'd2, 6'd63, 1'b0);
        send_req(2'd2, 6'd63);
        load_payload(1'b0);
        capture(-1, 0, 1'b0, -1);
        pl_q.delete();
        pl_q.push_back(8'h5A);
        build_expected(2'd0, 6'd1, 1'b0);
        send_req(2'd0, 6'd1);
        load_payload(1'b0);
        check8("b2b.hdr2", data_out, 8'h04);
        capture(-1, 0, 1'b0, -1);

        // Reset during payload, then a clean packet.
        pl_q.delete();
        pl_q.push_back(8'h11);
        pl_q.push_back(8'h22);
        pl_q.push_back(8'h33);
        build_expected(2'd1, 6'd3, 1'b0);
        send_req(2'd1, 6'd3);
        load_payload(1'b0);
        capture(-1, 0, 1'b0, 2);
        check1("post_rst.req_ready", req_ready, 1'b1);
        check1("post_rst.pkt_valid", pkt_valid, 1'b0);
        send_req(2'd1, 6'd3);
        load_payload(1'b0);
        capture(-1, 0, 1'b0, -1);

`ifdef ROUTER_TX_PARITY_INJ_EN
        // Corrupted parity on the first packet only.
        inj_err = 1'b1;
        build_expected(2'd1, 6'd3, 1'b1);
        send_req(2'd1, 6'd3);
        inj_err = 1'b0;
        load_payload(1'b0);
        check8("inj.parity_model", exp_d[4], 8'h0C);
        capture(-1, 0, 1'b0, -1);
        build_expected(2'd1, 6'd3, 1'b0);
        send_req(2'd1, 6'd3);
        load_payload(1'b0);
        capture(-1, 0, 1'b0, -1);
`endif

        // Randomized packets with back-pressure, load gaps and ignored side traffic.
        for (int n = 0; n < 25; n++) begin
            logic [1:0] a;
            logic [5:0] l;
            int         r;
            r = $urandom_range(0, 9);
            a = 2'($urandom_range(0, 2));
            l = 6'($urandom_range(1, 63));
            if (r == 0) a = 2'd3;
            if (r == 1) l = 6'd0;
            send_req(a, l);
            if (a == 2'd3 || l == 6'd0) begin
                check_drop();
            end else begin
                check1("rnd.no_drop", req_drop, 1'b0);
                pl_q.delete();
                for (int i = 0; i < int'(l); i++) pl_q.push_back(8'($urandom));
                build_expected(a, l, 1'b0);
                load_payload(1'b1);
                capture(-1, 0, 1'b1, -1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
